ternary_matmul_sequencer: RTL
=============================

// Module: ternary_matmul_sequencer
// PURPOSE
//  Sequences one ternary matrix-multiply job on the 1.58-bit systolic array.
//  Accepts a command (accumulation length K) and a handshaked stream of packed ternary weights plus int8 activations.
//  Aligns each beat to the array's free-running slice phase; clears, accumulates, snapshots and reads out results.
//  Sits between the host-facing input pins and the systolic_array control/data ports.
// PARAMETERS
//  SLICES      2  array time-multiplex factor; beats per K step (array slice counter period)
//  K_W         8  width of cmd_k
//  DRAIN_CYC   2  zero-weight cycles after last beat before snapshot (array arg reg + accumulate)
//  OUT_BEATS   4  result bytes presented per job (array out-queue depth)
// PORTS
//  clk               in   1    clock
//  reset             in   1    synchronous, active-high reset
//  cmd_valid         in   1    job request
//  cmd_ready         out  1    high only in IDLE
//  cmd_k             in   K_W  accumulation steps; 0 treated as 1
//  in_valid          in   1    input beat valid
//  in_ready          out  1    beat accepted when in_valid&in_ready
//  in_weights        in   8    4 packed 2-bit ternary weights (00=zero)
//  in_act            in   8    signed int8 activation
//  arr_weights       out  8    to array weights; 0 (all-zero weights) when no beat accepted
//  arr_act           out  8    to array activations; 0 when no beat accepted
//  arr_reset_acc     out  1    array reset_accumulators
//  arr_copy_out      out  1    array copy_accumulator_values_to_out_queue
//  arr_restart_queue out  1    array restart_out_queue
//  arr_out           in   8    array result byte
//  out_valid         out  1    result byte valid (no backpressure)
//  out_data          out  8    result byte = arr_out while out_valid
//  busy              out  1    state != IDLE
// BEHAVIOUR
//  - Reset: state=IDLE, phase=0, counters=0; all outputs 0 except cmd_ready=1.
//  - phase: mirror of array slice counter; reset with it, increments mod SLICES every cycle, in every state.
//  - IDLE: cmd_ready=1; on cmd_valid latch K=max(cmd_k,1), beats_total=K*SLICES (K_W+2 bits), go CLEAR.
//  - CLEAR: 1 cycle, arr_reset_acc=1; beat_idx=0; -> LOAD.
//  - LOAD: in_ready = (phase == beat_idx mod SLICES).
//    - On fire: arr_weights/arr_act = inputs (combinational, same cycle); beat_idx++.
//    - Missed slot (in_valid low while in_ready) costs a full SLICES rotation; drive zeros, never misalign.
//    - Fire of beat beats_total-1 -> DRAIN.
//  - DRAIN: DRAIN_CYC cycles, zeros driven, in_ready=0 -> SNAP.
//  - SNAP: 1 cycle, arr_copy_out=1 and arr_restart_queue=1 -> READOUT.
//  - READOUT: out_valid=1 for exactly OUT_BEATS consecutive cycles; cycle n shows queue entry n. Then -> IDLE.
//  - arr_reset_acc is 1 only in CLEAR; arr_copy_out and arr_restart_queue are 1 only in SNAP.
//  - cmd_valid outside IDLE is ignored (not queued). in_valid outside LOAD is ignored.
//  - cmd_valid in the READOUT last cycle is not seen; the earliest accept is the first IDLE cycle.
//  - Reset mid-job: abort to IDLE next edge; outputs at reset values; no partial readout continues.
//  - Counters never wrap within a job: beat_idx saturates at beats_total; K=2^K_W-1 must complete.
// TESTING
//  - Reset then idle 5 cycles -> cmd_ready=1, busy=0, every arr_* and out_valid = 0.
//  - cmd_k=1, in_valid held high, weights 0x55/0x55, act 3/5 -> 2 beats on phases 0,1. Then 1 CLEAR, 2 DRAIN, 1 SNAP pulse, 4 out_valid cycles.
//  - cmd_k=3, in_valid dropped on beat 2's slot -> beat 2 waits SLICES cycles; total LOAD = 6 beats + 2 cycles; accepted phases = beat_idx mod 2.
//  - cmd_k=0 -> behaves as cmd_k=1 (exactly 2 beats accepted).
//  - cmd_valid pulsed during LOAD and READOUT -> ignored; second job starts only after returning to IDLE.
//  - Assert reset in DRAIN -> next cycle IDLE, arr_copy_out never pulses, out_valid stays 0.

Source files
------------

// File: rtl/ternary_matmul_sequencer.sv
// ternary_matmul_sequencer
//
// Runs one ternary matrix-multiply job on the 1.58-bit systolic array. A command sets the
// accumulation length K. The bench-side stream of packed ternary weights and int8 activations
// is then aligned to the array's free-running slice phase. Each job clears the accumulators,
// streams K*SLICES beats, drains the array pipeline, snapshots the accumulators into the out
// queue and presents OUT_BEATS result bytes.
//
// Ports
//   clk, reset          clock; synchronous active-high reset
//   cmd_valid/ready     job request handshake (ready only while idle), cmd_k = K (0 means 1)
//   in_valid/ready      beat handshake; in_weights = 4 packed 2-bit weights, in_act = int8
//   arr_weights/act     beat data to the array, zero whenever no beat is accepted
//   arr_reset_acc       array accumulator clear (CLEAR state)
//   arr_copy_out        array accumulator -> out queue snapshot (SNAP state)
//   arr_restart_queue   array out-queue read pointer restart (SNAP state)
//   arr_out             array result byte
//   out_valid/out_data  result byte stream, no backpressure
//   busy                a job is in progress

module ternary_matmul_sequencer #(
    parameter int unsigned SLICES    = 2,
    parameter int unsigned K_W       = 8,
    parameter int unsigned DRAIN_CYC = 2,
    parameter int unsigned OUT_BEATS = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           cmd_valid,
    output logic           cmd_ready,
    input  logic [K_W-1:0] cmd_k,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [7:0]     in_weights,
    input  logic [7:0]     in_act,
    output logic [7:0]     arr_weights,
    output logic [7:0]     arr_act,
    output logic           arr_reset_acc,
    output logic           arr_copy_out,
    output logic           arr_restart_queue,
    input  logic [7:0]     arr_out,
    output logic           out_valid,
    output logic [7:0]     out_data,
    output logic           busy
);

    localparam int unsigned PH_W    = (SLICES > 1) ? $clog2(SLICES) : 1;
    localparam int unsigned BT_W    = K_W + 2;
    localparam int unsigned CNT_MAX = (DRAIN_CYC > OUT_BEATS) ? DRAIN_CYC : OUT_BEATS;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StLoad,
        StDrain,
        StSnap,
        StReadout
    } state_t;

    state_t            state_q, state_d;
    logic [PH_W-1:0]   phase_q, phase_d;
    logic [BT_W-1:0]   beat_idx_q, beat_idx_d;
    logic [BT_W-1:0]   beats_total_q, beats_total_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [K_W-1:0]    k_eff;
    logic [BT_W-1:0]   beat_mod;
    logic              slot_match;

    // phase mirrors the array's slice counter: it restarts with reset and never stalls.
    always_comb begin
        if (phase_q == PH_W'(SLICES - 1)) begin
            phase_d = '0;
        end else begin
            phase_d = phase_q + PH_W'(1);
        end
    end

    assign k_eff      = (cmd_k == '0) ? K_W'(1) : cmd_k;
    // Beat n must land on slice n mod SLICES, otherwise the array would mix up slices.
    assign beat_mod   = beat_idx_q % BT_W'(SLICES);
    assign slot_match = (phase_q == beat_mod[PH_W-1:0]);

    always_comb begin
        state_d           = state_q;
        beat_idx_d        = beat_idx_q;
        beats_total_d     = beats_total_q;
        cnt_d             = cnt_q;
        cmd_ready         = 1'b0;
        in_ready          = 1'b0;
        arr_weights       = 8'h00;
        arr_act           = 8'h00;
        arr_reset_acc     = 1'b0;
        arr_copy_out      = 1'b0;
        arr_restart_queue = 1'b0;
        out_valid         = 1'b0;
        out_data          = 8'h00;
        busy              = (state_q != StIdle);

        unique case (state_q)
            StIdle: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    beats_total_d = BT_W'(k_eff) * BT_W'(SLICES);
                    state_d       = StClear;
                end
            end
            StClear: begin
                arr_reset_acc = 1'b1;
                beat_idx_d    = '0;
                state_d       = StLoad;
            end
            StLoad: begin
                // The bound on beat_idx keeps the index saturating at beats_total.
                in_ready = slot_match && (beat_idx_q < beats_total_q);
                if (in_ready && in_valid) begin
                    arr_weights = in_weights;
                    arr_act     = in_act;
                    beat_idx_d  = beat_idx_q + BT_W'(1);
                    if (beat_idx_q == beats_total_q - BT_W'(1)) begin
                        cnt_d   = '0;
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                // Zero weights flush the array argument register and final accumulate.
                if (cnt_q == CNT_W'(DRAIN_CYC - 1)) begin
                    state_d = StSnap;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StSnap: begin
                arr_copy_out      = 1'b1;
                arr_restart_queue = 1'b1;
                cnt_d             = '0;
                state_d           = StReadout;
            end
            StReadout: begin
                out_valid = 1'b1;
                out_data  = arr_out;
                if (cnt_q == CNT_W'(OUT_BEATS - 1)) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            phase_q       <= '0;
            beat_idx_q    <= '0;
            beats_total_q <= '0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            phase_q       <= phase_d;
            beat_idx_q    <= beat_idx_d;
            beats_total_q <= beats_total_d;
            cnt_q         <= cnt_d;
        end
    end

endmodule
